// File: rtl/act_pkg.sv
// Shared types and constants for the activation requantise/pack path.
package act_pkg;
    localparam int ACT_FRAC_BITS = 8;
    localparam int INT8_MIN      = -128;
    localparam int INT8_MAX      = 127;
    localparam int PACK_LANES    = 4;

    // Signed Q8.8 activation as produced by the SiLU stage.
    typedef logic signed [15:0] act_q88_t;
    // One requantised int8 lane.
    typedef logic signed [7:0]  lane_t;
endpackage

// File: rtl/int8_quant.sv
// Combinational Q8.8 -> int8 requantiser: round-half-up arithmetic shift,
// then clamp to [-128,127]. sat_o flags a pre-clamp value outside that range.
module int8_quant
    import act_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  act_q88_t   data_i,
    output logic [7:0] q_o,
    output logic       sat_o
);
    localparam logic signed [16:0] ROUND = 17'sd1 <<< (SHIFT - 1);
    localparam logic signed [16:0] HI    = 17'(INT8_MAX);
    localparam logic signed [16:0] LO    = 17'(INT8_MIN);

    logic signed [16:0] ext;
    logic signed [16:0] biased;
    logic signed [16:0] shifted;
    logic               over_hi;
    logic               over_lo;

    // Seventeen bits keep the rounding add from wrapping at 0x7FFF.
    always_comb begin
        ext     = {data_i[15], data_i};
        biased  = ext + ROUND;
        shifted = biased >>> SHIFT;
        over_hi = shifted > HI;
        over_lo = shifted < LO;
        sat_o   = over_hi || over_lo;
        if (over_hi) begin
            q_o = 8'h7F;
        end else if (over_lo) begin
            q_o = 8'h80;
        end else begin
            q_o = shifted[7:0];
        end
    end
endmodule

// File: rtl/act_pack_int8.sv
// Requantises Q8.8 activations to int8 and packs four lanes little-endian
// into 32-bit words. Optional saturation counter: define ACT_PACK_STATS_EN.
module act_pack_int8
    import act_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_last,
    input  logic        out_ready,
    output logic [15:0] sat_count
);
    logic [1:0]                  cnt_q, cnt_d;
    logic [PACK_LANES-1:0][7:0]  lane_q, lane_d, word_w;
    logic [PACK_LANES-1:0]       keep_w;
    logic                        out_valid_q, out_valid_d;
    logic [31:0]                 out_data_q, out_data_d;
    logic [3:0]                  out_keep_q, out_keep_d;
    logic                        out_last_q, out_last_d;
    logic [7:0]                  quant_q;
    logic                        quant_sat;
    logic                        beat;
    logic                        complete;

    int8_quant #(.SHIFT(SHIFT)) u_quant (
        .data_i (act_q88_t'(in_data)),
        .q_o    (quant_q),
        .sat_o  (quant_sat)
    );

    // Ready depends only on the output register, never on in_valid.
    assign in_ready = !out_valid_q || out_ready;
    assign beat     = in_valid && in_ready;
    assign complete = beat && (cnt_q == 2'd3 || in_last);

    // Per-lane insert of the accepted byte; the pack register clears on word
    // completion so unused upper lanes of a short word read as zero.
    for (genvar gi = 0; gi < PACK_LANES; gi++) begin : g_lane
        assign word_w[gi] = (beat && cnt_q == 2'(gi)) ? quant_q : lane_q[gi];
        assign lane_d[gi] = complete ? 8'h00 : word_w[gi];
        assign keep_w[gi] = (2'(gi) <= cnt_q);
    end

    // Next-state for lane counter and output register (hold until accepted).
    always_comb begin
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (complete) begin
            cnt_d       = 2'd0;
            out_valid_d = 1'b1;
            out_data_d  = word_w;
            out_keep_d  = keep_w;
            out_last_d  = in_last;
        end else if (beat) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    // State registers; reset mid-word discards the partial word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= 2'd0;
            lane_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            out_keep_q  <= 4'h0;
            out_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            lane_q      <= lane_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;

`ifdef ACT_PACK_STATS_EN
    logic [15:0] sat_q;

    // Saturating count of accepted beats that clamped; sticks at 0xFFFF.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= 16'h0;
        end else if (beat && quant_sat && sat_q != 16'hFFFF) begin
            sat_q <= sat_q + 16'h1;
        end
    end

    assign sat_count = sat_q;
`else
    logic unused_quant_sat;

    assign unused_quant_sat = quant_sat;
    assign sat_count        = 16'h0;
`endif
endmodule

// File: tb/tb_act_pack_int8.sv
// Self-checking bench for act_pack_int8 against a spec-level reference model.
module tb_act_pack_int8;
    localparam int SHIFT = 4;
`ifdef ACT_PACK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef logic [36:0] wrec_t; // {last, keep[3:0], data[31:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic [15:0] sat_count;

    int    errors = 0;
    int    checks = 0;
    int    sat_ref = 0;
    int    m_cnt = 0;
    logic [31:0] m_word = 32'h0;
    bit    stall_seen = 1'b0;
    bit    drv_done = 1'b0;
    wrec_t exp_q[$];
    wrec_t got_q[$];

    act_pack_int8 #(.SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    // Record every word handshake (inputs change only at posedge+1).
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) got_q.push_back({out_last, out_keep, out_data});
    end

    // Pre-clamp value: round-half-up division by 2^SHIFT with floor semantics.
    function automatic int pre_clamp(input logic [15:0] d);
        int v, r, den;
        v   = int'($signed(d));
        den = 1 << SHIFT;
        r   = v + den / 2;
        if (r >= 0) return r / den;
        return -((-r + den - 1) / den);
    endfunction

    function automatic logic [7:0] qref(input logic [15:0] d);
        int s;
        s = pre_clamp(d);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return 8'(s);
    endfunction

    function automatic logic [15:0] sat_exp();
        if (!STATS) return 16'h0;
        return (sat_ref > 65535) ? 16'hFFFF : 16'(sat_ref);
    endfunction

    function automatic logic [15:0] rand_act();
        if ($urandom_range(0, 1) == 1) return 16'($signed(12'($urandom)));
        return 16'($urandom);
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_word = 32'h0;
        sat_ref = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    // Drive one beat from posedge+1; returns at posedge+1 after acceptance.
    task automatic send_beat(input logic [15:0] d, input bit l);
        int waits = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            stall_seen = 1'b1;
            @(negedge clk);
        end
        if (waits >= 200) begin
            errors++; checks++;
            $display("FAIL beat_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waits);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (pre_clamp(d) > 127 || pre_clamp(d) < -128) sat_ref++;
        m_word[8*m_cnt +: 8] = qref(d);
        if (m_cnt == 3 || l) begin
            exp_q.push_back({l, 4'((1 << (m_cnt + 1)) - 1), m_word});
            m_cnt = 0;
            m_word = 32'h0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        checks++; if (out_keep !== 4'h0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_keep_last: got %h/%0b want 0/0", out_keep, out_last); end
        checks++; if (sat_count !== 16'h0) begin errors++; $display("FAIL reset_sat: got %h want 0", sat_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        idle(1);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        model_reset();
        out_ready = 1'b1;
        send_beat(16'h0100, 1'b0);
        send_beat(16'hFF00, 1'b0);
        send_beat(16'h7FFF, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early: out_valid=%0b want 0", out_valid); end
        send_beat(16'h0018, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid=%0b want 1", out_valid); end
        checks++; if (out_data !== 32'h027FF010) begin errors++; $display("FAIL basic_data: got %h want 027ff010", out_data); end
        checks++; if (out_keep !== 4'hF || out_last !== 1'b1) begin errors++; $display("FAIL basic_keep_last: got %h/%0b want f/1", out_keep, out_last); end
        idle(2);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL basic_count: got %0d words want 1", got_q.size()); end
        checks++; if (sat_count !== sat_exp()) begin errors++; $display("FAIL basic_sat: got %h want %h", sat_count, sat_exp()); end
        $display("test_basic word=%h sat=%h", out_data, sat_count);
    endtask

    task automatic test_neg_boundary();
        logic [15:0] sat_before;
        sat_before = sat_count;
        got_q.delete(); exp_q.delete();
        send_beat(16'hF800, 1'b0);
        send_beat(16'h8000, 1'b1);
        checks++; if (out_data !== 32'h00008080) begin errors++; $display("FAIL neg_data: got %h want 00008080", out_data); end
        checks++; if (out_keep !== 4'h3 || out_last !== 1'b1) begin errors++; $display("FAIL neg_keep_last: got %h/%0b want 3/1", out_keep, out_last); end
        idle(2);
        checks++; if (sat_count !== (STATS ? sat_before + 16'h1 : 16'h0)) begin errors++; $display("FAIL neg_sat: got %h want %h", sat_count, STATS ? sat_before + 16'h1 : 16'h0); end
        $display("test_neg_boundary word=%h keep=%h", got_q.size() > 0 ? got_q[0][31:0] : 32'h0, out_keep);
    endtask

    task automatic compare_words(input string tag);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d words want %0d", tag, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_word%0d: got %h want %h", tag, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        got_q.delete(); exp_q.delete();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_beat(rand_act(), 1'b0);
            end
            begin
                int t = 0;
                @(negedge clk);
                while (!out_valid && t < 100) begin t++; @(negedge clk); end
                held = out_data;
                for (int c = 0; c < 6; c++) begin
                    @(negedge clk);
                    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %0b want 0", in_ready); end
                    checks++; if (out_data !== held || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold: got %h/%0b want %h/1", out_data, out_valid, held); end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        idle(3);
        compare_words("stall");
        $display("test_stall words=%0d", got_q.size());
    endtask

    task automatic test_back_to_back();
        got_q.delete(); exp_q.delete();
        out_ready = 1'b1;
        stall_seen = 1'b0;
        for (int i = 0; i < 16; i++) send_beat(rand_act(), 1'b0);
        idle(3);
        checks++; if (stall_seen !== 1'b0) begin errors++; $display("FAIL stream_ready: in_ready dropped, want never"); end
        compare_words("stream");
        $display("test_back_to_back words=%0d", got_q.size());
    endtask

    task automatic test_random_backpressure();
        got_q.delete(); exp_q.delete();
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) send_beat(rand_act(), $urandom_range(0, 3) == 0);
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        if (m_cnt != 0) send_beat(rand_act(), 1'b1);
        idle(3);
        compare_words("random");
        $display("test_random_backpressure words=%0d", got_q.size());
    endtask

    task automatic test_async_reset();
        logic [15:0] first;
        got_q.delete(); exp_q.delete();
        out_ready = 1'b1;
        send_beat(rand_act(), 1'b0);
        send_beat(rand_act(), 1'b0);
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL areset_out: got %0b/%h want 0/0", out_valid, out_data); end
        checks++; if (out_keep !== 4'h0 || out_last !== 1'b0 || sat_count !== 16'h0) begin errors++; $display("FAIL areset_misc: got %h/%0b/%h want 0/0/0", out_keep, out_last, sat_count); end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);
        first = 16'h0123;
        send_beat(first, 1'b0);
        for (int i = 0; i < 3; i++) send_beat(rand_act(), 1'b0);
        checks++; if (out_data[7:0] !== qref(first) || out_keep !== 4'hF) begin errors++; $display("FAIL areset_lane0: got %h/%h want %h/f", out_data[7:0], out_keep, qref(first)); end
        idle(2);
        compare_words("areset");
        $display("test_async_reset word=%h", out_data);
    endtask

    task automatic test_sat_stick();
        int n;
        n = STATS ? 70000 : 300;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            send_beat(16'h7FFF, 1'b0);
            if (i % 1000 == 0) begin got_q.delete(); exp_q.delete(); end
        end
        idle(2);
        checks++; if (sat_count !== sat_exp()) begin errors++; $display("FAIL sat_stick: got %h want %h", sat_count, sat_exp()); end
        $display("test_sat_stick beats=%0d sat=%h", n, sat_count);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_boundary();
        test_stall();
        test_back_to_back();
        test_random_backpressure();
        test_async_reset();
        test_sat_stick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
